sram_req_queue: RTL

//  Request buffer upstream of one port (A or B) of the dual-port SRAM arbiter.

---
 rtl/sram_req_pkg.sv | 19 +
 rtl/sram_req_fifo.sv | 59 +++++
 rtl/sram_req_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sram_req_pkg.sv
// Shared types for the SRAM request queue.
// sram_req_t stores one queued request: write flag, address and write data.
// The struct fields use the default 8-bit widths, so AW/DW stay at their
// defaults wherever this struct carries a request.
package sram_req_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } sram_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } req_state_t;
endpackage

// File: rtl/sram_req_fifo.sv
// DEPTH-entry synchronous FIFO of sram_req_t.
// Ports: clk, reset_n (async active-low), push/push_data, pop, head (current
// oldest entry), count (occupancy), full, empty.
// Push when full or pop when empty must be prevented by the caller.
module sram_req_fifo
    import sram_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  sram_req_t              push_data,
    input  logic                   pop,
    output sram_req_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    sram_req_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == (PW+1)'(DEPTH));
    assign empty = (r_count == '0);
endmodule

// File: rtl/sram_req_queue.sv
// Request buffer in front of one port of the dual-port SRAM arbiter.
// Requests enter via req_valid/req_ready, are issued one at a time as
// registered level signals port_w/port_r/port_d/port_a held until
// port_pronto, and complete as a one-cycle rsp_valid strobe carrying
// rsp_we/rsp_addr/rsp_rdata. count reports occupancy (including the entry
// in flight, which is only popped on its pronto edge).
// Optional macro QUEUE_STATS_EN adds saturating counters stat_rd, stat_wr
// (completed reads/writes) and stat_full (cycles with req_valid && !req_ready).
//
// state | meaning
// IDLE  | no request on the port; load the FIFO head if one is waiting
// ISSUE | request held on the port until port_pronto is sampled high
module sram_req_queue
    import sram_req_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [AW-1:0]          req_addr,
    input  logic [DW-1:0]          req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_we,
    output logic [AW-1:0]          rsp_addr,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   port_w,
    output logic                   port_r,
    output logic [DW-1:0]          port_d,
    output logic [AW-1:0]          port_a,
    input  logic [DW-1:0]          port_q,
    input  logic                   port_pronto,
    output logic [$clog2(DEPTH):0] count
`ifdef QUEUE_STATS_EN
    ,
    output logic [15:0]            stat_rd,
    output logic [15:0]            stat_wr,
    output logic [15:0]            stat_full
`endif
);
    req_state_t r_state, w_state_nxt;
    logic          r_port_w, w_port_w_nxt;
    logic          r_port_r, w_port_r_nxt;
    logic [DW-1:0] r_port_d, w_port_d_nxt;
    logic [AW-1:0] r_port_a, w_port_a_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic          r_rsp_we, w_rsp_we_nxt;
    logic [AW-1:0] r_rsp_addr, w_rsp_addr_nxt;
    logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

    logic      w_push;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    sram_req_t w_push_data;
    sram_req_t w_head;

    assign w_push      = req_valid && !w_full;
    assign w_push_data = '{we: req_we, addr: req_addr, data: req_wdata};

    sram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_port_w_nxt    = r_port_w;
        w_port_r_nxt    = r_port_r;
        w_port_d_nxt    = r_port_d;
        w_port_a_nxt    = r_port_a;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_we_nxt    = r_rsp_we;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                w_port_w_nxt = 1'b0;
                w_port_r_nxt = 1'b0;
                w_port_d_nxt = '0;
                w_port_a_nxt = '0;
                if (!w_empty) begin
                    w_port_w_nxt = w_head.we;
                    w_port_r_nxt = !w_head.we;
                    w_port_d_nxt = w_head.we ? w_head.data : '0;
                    w_port_a_nxt = w_head.addr;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (port_pronto) begin
                    // Head stays in the FIFO until now so count includes the request in flight.
                    w_pop           = 1'b1;
                    w_port_w_nxt    = 1'b0;
                    w_port_r_nxt    = 1'b0;
                    w_port_d_nxt    = '0;
                    w_port_a_nxt    = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_we_nxt    = r_port_w;
                    w_rsp_addr_nxt  = r_port_a;
                    w_rsp_rdata_nxt = r_port_w ? '0 : port_q;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_port_w    <= 1'b0;
            r_port_r    <= 1'b0;
            r_port_d    <= '0;
            r_port_a    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_port_w    <= w_port_w_nxt;
            r_port_r    <= w_port_r_nxt;
            r_port_d    <= w_port_d_nxt;
            r_port_a    <= w_port_a_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_we    <= w_rsp_we_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign req_ready = !w_full;
    assign port_w    = r_port_w;
    assign port_r    = r_port_r;
    assign port_d    = r_port_d;
    assign port_a    = r_port_a;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_rdata = r_rsp_rdata;

`ifdef QUEUE_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_rd   <= '0;
            r_stat_wr   <= '0;
            r_stat_full <= '0;
        end else begin
            if (w_pop && r_port_r && (r_stat_rd != 16'hFFFF)) begin
                r_stat_rd <= r_stat_rd + 16'd1;
            end
            if (w_pop && r_port_w && (r_stat_wr != 16'hFFFF)) begin
                r_stat_wr <= r_stat_wr + 16'd1;
            end
            if (req_valid && w_full && (r_stat_full != 16'hFFFF)) begin
                r_stat_full <= r_stat_full + 16'd1;
            end
        end
    end

    assign stat_rd   = r_stat_rd;
    assign stat_wr   = r_stat_wr;
    assign stat_full = r_stat_full;
`endif
endmodule
